// File: rtl/spi_master_xfer_ctrl.sv
// spi_master_xfer_ctrl: SPI master transfer sequencer with a one-deep TX buffer.
// Ports: PClk/PRESET, spe/mstr/cpha/lsbfe config, tx_valid/tx_data write, rd_ack,
//   flag_shift/flag_sample baud strobes, miso in; ss, sclk_en, mosi, rx_data,
//   spif, wcol, tx_empty, busy out. Optional: SPI_CONT_XFER_EN keeps SS low
//   between back-to-back words.
module spi_master_xfer_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int SETUP_CYC  = 2,
  parameter int HOLD_CYC   = 2
) (
  input  logic                  PClk,
  input  logic                  PRESET,
  input  logic                  spe,
  input  logic                  mstr,
  input  logic                  cpha,
  input  logic                  lsbfe,
  input  logic                  tx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  rd_ack,
  input  logic                  flag_shift,
  input  logic                  flag_sample,
  input  logic                  miso,
  output logic                  ss,
  output logic                  sclk_en,
  output logic                  mosi,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  spif,
  output logic                  wcol,
  output logic                  tx_empty,
  output logic                  busy
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam int IW = $clog2(DATA_WIDTH);
  localparam int CMAX = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int CCW = (CMAX > 1) ? $clog2(CMAX + 1) : 1;

`ifdef SPI_CONT_XFER_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] buf_q;
  logic [DATA_WIDTH-1:0] sh_q;
  logic [DATA_WIDTH-1:0] rx_q;
  logic [CW-1:0]         bit_cnt_q;
  logic [CCW-1:0]        cyc_q;
  logic                  tx_empty_q;
  logic                  ss_q;
  logic                  sclk_en_q;
  logic                  mosi_q;
  logic                  spif_q;
  logic                  wcol_q;

  logic [DATA_WIDTH-1:0] sh_d;
  logic [CW-1:0]         cnt_d;
  logic                  en;
  logic                  samp;
  logic                  shft;
  logic                  done;
  logic                  hold_last;
  logic                  go;

  // Bit index for transfer position k in the selected bit order.
  function automatic logic [IW-1:0] bpos(
    input logic [IW-1:0] k,
    input logic          lsb
  );
    return lsb ? k : (IW'(DATA_WIDTH - 1) - k);
  endfunction

  assign en        = spe & mstr;
  assign hold_last = (state_q == HOLD) &&
                     (cyc_q == CCW'(HOLD_CYC - 1));
  assign go        = en && !tx_empty_q &&
                     ((state_q == IDLE) || (CONT && hold_last));

  // Sample lands before the shift; the shift then reads the bit
  // at the post-sample count, which is never overwritten yet.
  always_comb begin
    sh_d  = sh_q;
    cnt_d = bit_cnt_q;
    samp  = (state_q == XFER) && flag_sample &&
            (bit_cnt_q != CW'(DATA_WIDTH));
    if (samp) begin
      sh_d[bpos(bit_cnt_q[IW-1:0], lsbfe)] = miso;
      cnt_d = bit_cnt_q + CW'(1);
    end
    done = samp && (cnt_d == CW'(DATA_WIDTH));
    // cpha=0: bit 0 is already on mosi from SETUP, so
    // shifts before the first sample are ignored.
    shft = (state_q == XFER) && flag_shift &&
           (cnt_d != CW'(DATA_WIDTH)) &&
           (cpha || (cnt_d != '0));
  end

  always_ff @(posedge PClk or posedge PRESET) begin
    if (PRESET) begin
      state_q    <= IDLE;
      buf_q      <= '0;
      sh_q       <= '0;
      rx_q       <= '0;
      bit_cnt_q  <= '0;
      cyc_q      <= '0;
      tx_empty_q <= 1'b1;
      ss_q       <= 1'b1;
      sclk_en_q  <= 1'b0;
      mosi_q     <= 1'b0;
      spif_q     <= 1'b0;
      wcol_q     <= 1'b0;
    end else begin
      if (rd_ack) begin
        spif_q <= 1'b0;
        wcol_q <= 1'b0;
      end
      if (tx_valid) begin
        if (tx_empty_q) begin
          buf_q      <= tx_data;
          tx_empty_q <= 1'b0;
        end else begin
          wcol_q <= 1'b1;
        end
      end
      if (!en) begin
        state_q    <= IDLE;
        ss_q       <= 1'b1;
        sclk_en_q  <= 1'b0;
        bit_cnt_q  <= '0;
        cyc_q      <= '0;
        tx_empty_q <= 1'b1;
      end else if (go) begin
        state_q    <= SETUP;
        ss_q       <= 1'b0;
        sclk_en_q  <= 1'b0;
        sh_q       <= buf_q;
        mosi_q     <= buf_q[bpos('0, lsbfe)];
        tx_empty_q <= 1'b1;
        bit_cnt_q  <= '0;
        cyc_q      <= '0;
      end else begin
        unique case (state_q)
          IDLE: ss_q <= 1'b1;
          SETUP: begin
            if (cyc_q == CCW'(SETUP_CYC - 1)) begin
              state_q   <= XFER;
              sclk_en_q <= 1'b1;
              cyc_q     <= '0;
            end else begin
              cyc_q <= cyc_q + CCW'(1);
            end
          end
          XFER: begin
            sh_q      <= sh_d;
            bit_cnt_q <= cnt_d;
            if (shft) begin
              mosi_q <= sh_d[bpos(cnt_d[IW-1:0], lsbfe)];
            end
            // Completion overrides a coincident rd_ack.
            if (done) begin
              sclk_en_q <= 1'b0;
              rx_q      <= sh_d;
              spif_q    <= 1'b1;
              state_q   <= HOLD;
              cyc_q     <= '0;
            end
          end
          HOLD: begin
            if (hold_last) begin
              state_q <= IDLE;
              ss_q    <= 1'b1;
            end else begin
              cyc_q <= cyc_q + CCW'(1);
            end
          end
        endcase
      end
    end
  end

  assign ss       = ss_q;
  assign sclk_en  = sclk_en_q;
  assign mosi     = mosi_q;
  assign rx_data  = rx_q;
  assign spif     = spif_q;
  assign wcol     = wcol_q;
  assign tx_empty = tx_empty_q;
  assign busy     = (state_q != IDLE);

endmodule
